mandel_iter_engine: RTL and testbench

//  Parametrised Mandelbrot escape-time engine: one z <- z^2 + c iteration per clock.

---
 rtl/mandel_pkg.sv | 42 ++++
 rtl/mandel_iter_engine_fx_mult.sv | 25 ++
 rtl/mandel_iter_engine.sv | 149 ++++++++++++++
 tb/tb_mandel_iter_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// mandel_pkg: shared types and fixed-point helpers for the Mandelbrot engine.
//   state_t       FSM encoding (IDLE, ITER, DONE)
//   fx_one/two/four  fixed-point constants 1.0/2.0/4.0 as a function of FRAC
//   ONE_FX/TWO_FX/FOUR_FX  the same constants for the default FRAC of 23
//   fx_sat        clamp a 64-bit signed value into a signed field of `width` bits
package mandel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  localparam int DEF_FRAC = 23;

  function automatic logic signed [63:0] fx_one(input int frac);
    return 64'sd1 <<< frac;
  endfunction

  function automatic logic signed [63:0] fx_two(input int frac);
    return 64'sd2 <<< frac;
  endfunction

  function automatic logic signed [63:0] fx_four(input int frac);
    return 64'sd4 <<< frac;
  endfunction

  localparam logic signed [63:0] ONE_FX  = fx_one(DEF_FRAC);
  localparam logic signed [63:0] TWO_FX  = fx_two(DEF_FRAC);
  localparam logic signed [63:0] FOUR_FX = fx_four(DEF_FRAC);

  function automatic logic signed [63:0] fx_sat(input logic signed [63:0] v, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/mandel_iter_engine_fx_mult.sv
// fx_mult: signed fixed-point multiply, Q(WIDTH-FRAC).FRAC in and out.
//   a, b  signed WIDTH operands
//   p     full 2*WIDTH product, arithmetic-shifted right by FRAC (truncates
//         toward -inf), saturated to WIDTH. WIDTH must not exceed 32.
module fx_mult
  import mandel_pkg::*;
#(
  parameter int WIDTH = 27,
  parameter int FRAC  = 23
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [63:0]        shifted;

  always_comb begin
    prod    = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    shifted = 64'(prod >>> FRAC);
    p       = WIDTH'(fx_sat(shifted, WIDTH));
  end

endmodule

// File: rtl/mandel_iter_engine.sv
// mandel_iter_engine: Mandelbrot escape-time engine, one z <- z^2 + c step per clock.
//   clk, reset_n              clock, asynchronous active-low reset
//   start_valid/start_ready   point handshake; cr, ci (signed Q.FRAC), max_iter
//   result_valid/result_ready result handshake; result_iter, result_escaped
// Optional feature macro MANDEL_ESCAPE_Z_EN adds result_zr/result_zi, the final z.
module mandel_iter_engine
  import mandel_pkg::*;
#(
  parameter int WIDTH  = 27,
  parameter int FRAC   = 23,
  parameter int ITER_W = 13
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic signed [WIDTH-1:0]  cr,
  input  logic signed [WIDTH-1:0]  ci,
  input  logic [ITER_W-1:0]        max_iter,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [ITER_W-1:0]        result_iter,
  output logic                     result_escaped
`ifdef MANDEL_ESCAPE_Z_EN
  ,
  output logic signed [WIDTH-1:0]  result_zr,
  output logic signed [WIDTH-1:0]  result_zi
`endif
);

  localparam int SW = WIDTH + 2;
  localparam logic signed [SW-1:0] TWO_W  = SW'(fx_two(FRAC));
  localparam logic signed [SW-1:0] FOUR_W = SW'(fx_four(FRAC));

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [SW-1:0] v);
    return WIDTH'(fx_sat(64'(v), WIDTH));
  endfunction

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] zr, zi, cr_q, ci_q;
  logic [ITER_W-1:0]       max_q, iter_cnt, cnt_nxt;

  logic signed [WIDTH-1:0] sq_r, sq_i, x_ri;
  logic signed [WIDTH-1:0] zr_n, zi_n, mr_n, mi_n;
  logic signed [SW-1:0]    zr_sum, zi_sum, zr_abs, zi_abs, mag;
  logic                    escape, last;

  // Step products from the registered z.
  fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_rr (.a(zr), .b(zr), .p(sq_r));
  fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ii (.a(zi), .b(zi), .p(sq_i));
  fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ri (.a(zr), .b(zi), .p(x_ri));

  // Squares of the new z, so the escape decision lands on the same edge as the step.
  // Saturation here is harmless: any component that large already fails |z|<2.
  fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mag_r (.a(zr_n), .b(zr_n), .p(mr_n));
  fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mag_i (.a(zi_n), .b(zi_n), .p(mi_n));

  always_comb begin
    zr_sum  = SW'(sq_r) - SW'(sq_i) + SW'(cr_q);
    zi_sum  = (SW'(x_ri) <<< 1) + SW'(ci_q);
    zr_n    = sat_w(zr_sum);
    zi_n    = sat_w(zi_sum);
    // Component tests use the unsaturated sums, so negative overflow still escapes.
    zr_abs  = (zr_sum < 0) ? -zr_sum : zr_sum;
    zi_abs  = (zi_sum < 0) ? -zi_sum : zi_sum;
    mag     = SW'(mr_n) + SW'(mi_n);
    escape  = (zr_abs >= TWO_W) || (zi_abs >= TWO_W) || (mag >= FOUR_W);
    cnt_nxt = iter_cnt + 1'b1;
    last    = (cnt_nxt == max_q);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_valid) state_nxt = (max_iter == '0) ? DONE : ITER;
      ITER: if (escape || last) state_nxt = DONE;
      DONE: if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    start_ready  = reset_n && (state == IDLE);
    result_valid = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zr             <= '0;
      zi             <= '0;
      cr_q           <= '0;
      ci_q           <= '0;
      max_q          <= '0;
      iter_cnt       <= '0;
      result_iter    <= '0;
      result_escaped <= 1'b0;
`ifdef MANDEL_ESCAPE_Z_EN
      result_zr      <= '0;
      result_zi      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            cr_q     <= cr;
            ci_q     <= ci;
            max_q    <= max_iter;
            zr       <= '0;
            zi       <= '0;
            iter_cnt <= '0;
            if (max_iter == '0) begin
              result_iter    <= '0;
              result_escaped <= 1'b0;
`ifdef MANDEL_ESCAPE_Z_EN
              result_zr      <= '0;
              result_zi      <= '0;
`endif
            end
          end
        end
        ITER: begin
          zr       <= zr_n;
          zi       <= zi_n;
          iter_cnt <= cnt_nxt;
          if (escape || last) begin
            result_iter    <= cnt_nxt;
            result_escaped <= escape;
`ifdef MANDEL_ESCAPE_Z_EN
            result_zr      <= zr_n;
            result_zi      <= zi_n;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_iter_engine.sv
module tb_mandel_iter_engine;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               start_valid;
  logic               start_ready;
  logic signed [26:0] cr, ci;
  logic [12:0]        max_iter;
  logic               result_valid;
  logic               result_ready;
  logic [12:0]        result_iter;
  logic               result_escaped;
`ifdef MANDEL_ESCAPE_Z_EN
  logic signed [26:0] result_zr, result_zi;
`endif

  mandel_iter_engine #(.WIDTH(27), .FRAC(23), .ITER_W(13)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .cr             (cr),
    .ci             (ci),
    .max_iter       (max_iter),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_iter    (result_iter),
    .result_escaped (result_escaped)
`ifdef MANDEL_ESCAPE_Z_EN
    ,
    .result_zr      (result_zr),
    .result_zi      (result_zi)
`endif
  );

  always #5 clk = ~clk;

  // Edge counter; read at negedges only.
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // lat: edges from the accepting edge (inclusive) until result_valid is visible.
  typedef struct {
    int     iter;
    bit     esc;
    longint lat;
    int     stall;
    longint acc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic signed [26:0] fx(input real v);
    return 27'($rtoi(v * 8388608.0));
  endfunction

  // Monitor / scoreboard
  bit           seen      = 0;
  bit           post_hs   = 0;
  int           stall_left = 0;
  logic [12:0]  held_iter;
  logic         held_esc;
  exp_t         cur;

  initial result_ready = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (result_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 1, 0);
            stall_left = 0;
          end else begin
            cur = q[0];
            chk("result_iter", result_iter, cur.iter);
            chk("result_escaped", result_escaped, cur.esc);
            chk("latency", cyc - cur.acc, cur.lat);
            stall_left = cur.stall;
          end
          held_iter = result_iter;
          held_esc  = result_escaped;
          seen      = 1;
        end else begin
          chk("hold_iter", result_iter, held_iter);
          chk("hold_escaped", result_escaped, held_esc);
          chk("start_ready_busy", start_ready, 0);
        end
        if (stall_left > 0) begin
          result_ready = 1'b0;
          stall_left--;
        end else begin
          result_ready = 1'b1;
          if (q.size() != 0) void'(q.pop_front());
          seen    = 0;
          post_hs = 1;
        end
      end else begin
        if (post_hs) begin
          chk("start_ready_after_hs", start_ready, 1);
          post_hs = 0;
        end
        result_ready = 1'b0;
      end
    end
  end

  task automatic send(input real r, input real i, input int mx,
                      input int eit, input bit eesc, input int stall);
    exp_t e;
    bit   ok;
    ok = 0;
    @(negedge clk);
    cr          = fx(r);
    ci          = fx(i);
    max_iter    = 13'(mx);
    start_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (start_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      start_valid = 1'b0;
      return;
    end
    e.iter  = eit;
    e.esc   = eesc;
    e.lat   = (mx == 0) ? 1 : eit + 1;
    e.stall = stall;
    e.acc   = cyc;
    q.push_back(e);
    @(posedge clk);
    #1;
    // Scramble inputs; the engine must work from its latched copies.
    start_valid = 1'b0;
    cr          = fx(3.3);
    ci          = fx(-3.3);
    max_iter    = 13'd1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      if (q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("result_timeout", 0, 1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    start_valid = 1'b0;
    cr          = '0;
    ci          = '0;
    max_iter    = '0;
    #1;
    chk("rst_start_ready", start_ready, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_result_iter", result_iter, 0);
    chk("rst_result_escaped", result_escaped, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("idle_start_ready", start_ready, 1);

    //    cr     ci    max   iter esc stall
    send( 0.0,   0.0, 1000, 1000, 0, 0); wait_idle();
    send( 1.0,   0.0, 1000,    2, 1, 0); wait_idle();
    send(-2.0,   0.0, 1000,    1, 1, 0); wait_idle();
    send( 1.0,   0.0,    0,    0, 0, 0); wait_idle();
    send( 1.0,   0.0, 1000,    2, 1, 5); wait_idle();
    send(-1.5,   1.5, 1000,    1, 1, 0); wait_idle();
    send( 0.5,   0.0,    5,    5, 1, 0); wait_idle();
    send( 0.5,   0.0,    4,    4, 0, 0); wait_idle();
    send(-1.0,   0.0,    7,    7, 0, 0); wait_idle();
    send( 0.0,   1.0,    5,    5, 0, 0); wait_idle();
    send(-7.0,   0.0,  100,    1, 1, 0); wait_idle();
    send( 0.0,   0.0,    1,    1, 0, 0); wait_idle();

    // Abort a long run with reset; no result may appear.
    send(0.0, 0.0, 1000, 1000, 0, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_result_valid", result_valid, 0);
    chk("abort_start_ready", start_ready, 0);
    chk("abort_result_iter", result_iter, 0);
    q.delete();
    seen       = 0;
    post_hs    = 0;
    stall_left = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_abort_start_ready", start_ready, 1);
    chk("post_abort_result_valid", result_valid, 0);
    send(-2.0, 0.0, 1000, 1, 1, 0); wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
